stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per one-second tick (>=2).
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per display digit-scan step (>=1).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 start_stop  input  1  one-cycle command pulse, synchronous to clk: start, resume or pause.
REQ-006 clear  input  1  one-cycle command pulse: zero the count, honoured only in PAUSE.
REQ-007 lap  input  1  one-cycle command pulse: freeze or release the displayed value.
REQ-008 sec_out  output  6  displayed seconds, 0..59, binary; drives the two-digit seconds segment decoder.
REQ-009 min_out  output  6  displayed minutes, 0..59, binary; drives the minutes decoder.
REQ-010 running  output  1  high in RUN or LAP.
REQ-011 lapped  output  1  high in LAP (display frozen).
REQ-012 tick  output  1  one-cycle pulse on each one-second count increment.
REQ-013 an  output  4  active-low one-hot digit enable for the multiplexed display.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE, LAP.
REQ-015 IDLE: start_stop -> RUN; clear and lap ignored.
REQ-016 RUN: start_stop -> PAUSE; else lap -> LAP; clear ignored; start_stop has priority over simultaneous lap.
REQ-017 LAP: start_stop -> PAUSE with freeze released; else lap -> RUN with freeze released; clear ignored.
REQ-018 PAUSE: clear -> IDLE; else start_stop -> RUN; clear has priority over simultaneous start_stop; lap ignored.
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 in RUN and LAP, hold its value in PAUSE, and be forced to 0 in IDLE.
REQ-020 tick SHALL be high combinationally when state is RUN or LAP and prescaler == TICK_DIV-1; on that edge the prescaler wraps to 0 and the count increments.
REQ-021 Seconds count SHALL increment per tick; 59 wraps to 0 and carries +1 into minutes.
REQ-022 Minutes count SHALL wrap 59 -> 0 on carry; 59:59 + tick = 00:00, no overflow flag.
REQ-023 The transition to IDLE on clear SHALL zero seconds, minutes and prescaler on the same edge.
REQ-024 Entering LAP SHALL latch the pre-increment live count into a hold register (value before any same-edge tick).
REQ-025 sec_out/min_out SHALL equal the hold register in LAP, otherwise the live count with zero added latency after the updating edge.
REQ-026 Counting SHALL continue internally during LAP; on exit the outputs show the live count on the next cycle.
REQ-027 Scan counter SHALL advance the digit index 0->1->2->3->0 every SCAN_DIV cycles in all states; an = 1110, 1101, 1011, 0111 for index 0..3.

Reset
REQ-028 While reset is high, regardless of clk, the block SHALL hold state = IDLE, prescaler/counts/hold/scan = 0, sec_out = 0, min_out = 0, running = 0, lapped = 0, tick = 0, an = 4'b1110.
REQ-029 Reset asserted mid-RUN/LAP SHALL clear everything immediately with no clock edge required; counting does not resume until a new start_stop pulse.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-030 Reset, start_stop pulse, 240 cycles -> 60 tick pulses, sec_out=0, min_out=1, running=1.
REQ-031 Run to sec 10 plus 2 prescaler cycles, pause, idle 100 cycles -> sec_out stays 10; resume -> next tick after exactly 2 cycles.
REQ-032 Lap at sec 5 -> sec_out=5, lapped=1 while ticks continue; second lap at live sec 9 -> sec_out=9 next cycle, lapped=0.
REQ-033 Count at 59:59, one tick -> 00:00, running stays 1.
REQ-034 clear in RUN -> no effect; pause at 00:07 then clear+start_stop same cycle -> IDLE, 00:00, running=0.
REQ-035 Assert reset asynchronously between edges mid-RUN at 03:21 -> outputs 00:00 and an=1110 before next edge; an rotates every 2 cycles after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap FSM, mm:ss counter,
// one-second prescaler and 4-digit display scan.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic       running,
  output logic       lapped,
  output logic       tick,
  output logic [3:0] an
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LAP
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [5:0]    r_hold_sec;
  logic [5:0]    r_hold_min;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_scan_idx;
  logic          w_active;
  logic          w_clr;

  assign w_active = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_clr    = (r_state == S_PAUSE) && clear;
  assign tick     = w_active && (r_presc == TMAX);
  assign running  = w_active;
  assign lapped   = (r_state == S_LAP);
  assign sec_out  = lapped ? r_hold_sec : r_sec;
  assign min_out  = lapped ? r_hold_min : r_min;

  // Control FSM; entering LAP snapshots the pre-tick live count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold_sec <= '0;
      r_hold_min <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_stop) r_state <= S_RUN;
        end
        S_RUN: begin
          if (start_stop) begin
            r_state <= S_PAUSE;
          end else if (lap) begin
            r_state    <= S_LAP;
            r_hold_sec <= r_sec;
            r_hold_min <= r_min;
          end
        end
        S_LAP: begin
          if (start_stop)  r_state <= S_PAUSE;
          else if (lap)    r_state <= S_RUN;
        end
        S_PAUSE: begin
          if (clear)           r_state <= S_IDLE;
          else if (start_stop) r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Prescaler and mm:ss counter; holds in PAUSE, zeroed on clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
    end else if (r_state == S_IDLE) begin
      r_presc <= '0;
    end else if (w_active) begin
      if (tick) begin
        r_presc <= '0;
        if (r_sec == 6'd59) begin
          r_sec <= '0;
          r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Digit scan runs in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == SMAX) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Active-low one-hot digit enable
  always_comb begin
    an = 4'b1110;
    unique case (r_scan_idx)
      2'd0: an = 4'b1110;
      2'd1: an = 4'b1101;
      2'd2: an = 4'b1011;
      2'd3: an = 4'b0111;
      default: an = 4'b1110;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, SCAN_DIV=2.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [5:0] sec_out;
  logic [5:0] min_out;
  logic       running;
  logic       lapped;
  logic       tick;
  logic [3:0] an;

  int n_cmp = 0;
  int n_err = 0;
  int n_tick = 0;

  stopwatch_ctrl #(
    .TICK_DIV(4),
    .SCAN_DIV(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .sec_out   (sec_out),
    .min_out   (min_out),
    .running   (running),
    .lapped    (lapped),
    .tick      (tick),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    if (tick) n_tick++;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic s, input logic c, input logic l);
    start_stop = s;
    clear = c;
    lap = l;
    step();
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    n_tick = 0;
  endtask

  initial begin
    logic [3:0] an_exp [8];
    int cyc;
    an_exp = '{4'b1110, 4'b1101, 4'b1101, 4'b1011,
               4'b1011, 4'b0111, 4'b0111, 4'b1110};

    // reset state
    #2;
    chk("rst_sec", sec_out, 0);
    chk("rst_min", min_out, 0);
    chk("rst_run", running, 0);
    chk("rst_lap", lapped, 0);
    chk("rst_tick", tick, 0);
    chk("rst_an", an, 4'b1110);
    do_reset();

    // IDLE ignores lap/clear; then 240 cycles -> 1:00
    pulse(0, 0, 1);
    pulse(0, 1, 0);
    chk("idle_run", running, 0);
    chk("idle_lap", lapped, 0);
    pulse(1, 0, 0);
    n_tick = 0;
    steps(240);
    chk("a_ticks", n_tick, 60);
    chk("a_sec", sec_out, 0);
    chk("a_min", min_out, 1);
    chk("a_run", running, 1);

    // pause at sec 10 + 2 prescaler cycles, resume latency
    do_reset();
    pulse(1, 0, 0);
    steps(40);
    chk("b_sec10", sec_out, 10);
    step();
    pulse(1, 0, 0);
    chk("b_paused", running, 0);
    n_tick = 0;
    steps(100);
    pulse(0, 0, 1);
    chk("b_hold", sec_out, 10);
    chk("b_noticks", n_tick, 0);
    chk("b_nolap", lapped, 0);
    pulse(1, 0, 0);
    chk("b_resumed", running, 1);
    cyc = 0;
    while (!tick && cyc < 10) begin
      step();
      cyc++;
    end
    chk("b_resume_lat", cyc + 1, 2);
    step();
    chk("b_sec11", sec_out, 11);

    // lap freeze and release
    do_reset();
    pulse(1, 0, 0);
    steps(20);
    pulse(0, 0, 1);
    chk("c_lapped", lapped, 1);
    chk("c_sec5", sec_out, 5);
    chk("c_run", running, 1);
    n_tick = 0;
    steps(15);
    chk("c_frozen", sec_out, 5);
    chk("c_ticks", n_tick, 4);
    pulse(0, 0, 1);
    chk("c_sec9", sec_out, 9);
    chk("c_unlap", lapped, 0);
    steps(2);
    chk("c_tick_hi", tick, 1);
    pulse(0, 0, 1);
    chk("c_pretick", sec_out, 9);
    chk("c_lap2", lapped, 1);
    pulse(1, 0, 0);
    chk("c_exit_sec", sec_out, 10);
    chk("c_exit_run", running, 0);
    chk("c_exit_lap", lapped, 0);

    // clear ignored in RUN; clear wins over start_stop in PAUSE
    do_reset();
    pulse(1, 0, 0);
    steps(12);
    pulse(0, 1, 0);
    chk("d_clr_run", sec_out, 3);
    chk("d_still_run", running, 1);
    steps(15);
    pulse(1, 0, 0);
    chk("d_sec7", sec_out, 7);
    pulse(1, 1, 0);
    chk("d_idle_sec", sec_out, 0);
    chk("d_idle_min", min_out, 0);
    chk("d_idle_run", running, 0);
    n_tick = 0;
    steps(8);
    chk("d_idle_tick", n_tick, 0);
    chk("d_idle_sec2", sec_out, 0);

    // async reset mid-run at 03:21, then scan rotation
    do_reset();
    pulse(1, 0, 0);
    steps(804);
    chk("e_min3", min_out, 3);
    chk("e_sec21", sec_out, 21);
    steps(2);
    #3 reset = 1'b1;
    #1;
    chk("e_async_sec", sec_out, 0);
    chk("e_async_min", min_out, 0);
    chk("e_async_an", an, 4'b1110);
    chk("e_async_run", running, 0);
    #2 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("e_an", an, an_exp[k]);
    end
    chk("e_norun", running, 0);
    chk("e_nosec", sec_out, 0);

    // 59:59 wraps to 00:00
    do_reset();
    pulse(1, 0, 0);
    steps(14396);
    chk("f_min59", min_out, 59);
    chk("f_sec59", sec_out, 59);
    steps(4);
    chk("f_wrap_min", min_out, 0);
    chk("f_wrap_sec", sec_out, 0);
    chk("f_wrap_run", running, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
